video_timing_m: RTL and testbench

Generates the 640x480@60 Hz VGA raster timing for the GPU and the pixel coordinates consumed by the background and foreground renderers. It sits directly upstream of the background stage. It drives that stage's `current_x`/`current_y` inputs so that the 256x240 game area is scaled 2x into a 512x480 window, horizontally centred. It also emits the sync, visible and vblank strobes, delayed to line up with the downstream pixel pipeline.

---
 rtl/video_timing_m_if.sv | 23 ++
 rtl/video_timing_m.sv | 143 ++++++++++++++
 tb/tb_video_timing_m.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/video_timing_m_if.sv
// Raster coordinate and sync bundle from the timing generator to the render stages.
interface video_timing_m_if;
    logic [7:0] current_x;
    logic [7:0] current_y;
    logic       in_game;
    logic       hsync;
    logic       vsync;
    logic       visible;
    logic       line_start;
    logic       vblank_start;

    modport master (
        output current_x, current_y, in_game,
        output hsync, vsync, visible,
        output line_start, vblank_start
    );

    modport slave (
        input current_x, current_y, in_game,
        input hsync, vsync, visible,
        input line_start, vblank_start
    );
endinterface

// File: rtl/video_timing_m.sv
// VGA raster timing generator: free-running h/v counters, registered decode of
// 2x-scaled game-area coordinates, and sync/visible strobes delayed by SYNC_DELAY.
module video_timing_m #(
    parameter int unsigned H_VISIBLE     = 640,
    parameter int unsigned H_FRONT       = 16,
    parameter int unsigned H_SYNC        = 96,
    parameter int unsigned H_BACK        = 48,
    parameter int unsigned V_VISIBLE     = 480,
    parameter int unsigned V_FRONT       = 10,
    parameter int unsigned V_SYNC        = 2,
    parameter int unsigned V_BACK        = 33,
    parameter int unsigned GAME_X_OFFSET = 64,
    parameter int unsigned SYNC_DELAY    = 1
) (
    input  logic              gpu_clk,
    input  logic              rst,
    video_timing_m_if.master  o_vid
);

    localparam int unsigned CNT_W        = 10;
    localparam int unsigned H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned H_SYNC_FIRST = H_VISIBLE + H_FRONT;
    localparam int unsigned H_SYNC_LAST  = H_SYNC_FIRST + H_SYNC - 1;
    localparam int unsigned V_SYNC_FIRST = V_VISIBLE + V_FRONT;
    localparam int unsigned V_SYNC_LAST  = V_SYNC_FIRST + V_SYNC - 1;
    localparam int unsigned GAME_W       = 512;
    localparam int unsigned GAME_X_LAST  = GAME_X_OFFSET + GAME_W - 1;
    localparam int unsigned STRB_W       = 3;
    localparam int unsigned PIPE_W       = STRB_W * (SYNC_DELAY + 1);

    // Strobe bundle bit positions inside each pipeline stage
    localparam int unsigned B_HS  = 2;
    localparam int unsigned B_VS  = 1;
    localparam int unsigned B_VIS = 0;
    localparam logic [STRB_W-1:0] STRB_IDLE = 3'b110;

    logic [CNT_W-1:0]  r_hc;
    logic [CNT_W-1:0]  r_vc;
    logic              w_h_last;
    logic              w_v_last;

    logic              w_v_act;
    logic              w_in_game;
    logic [7:0]        w_cx;
    logic [7:0]        w_cy;
    logic              w_line_start;
    logic              w_vblank_start;
    logic [STRB_W-1:0] w_strb;

    logic [7:0]        r_cx;
    logic [7:0]        r_cy;
    logic              r_in_game;
    logic              r_line_start;
    logic              r_vblank_start;
    logic [PIPE_W-1:0] r_pipe;

    assign w_h_last = (r_hc == CNT_W'(H_TOTAL - 1));
    assign w_v_last = (r_vc == CNT_W'(V_TOTAL - 1));

    // Raster position counters
    always_ff @(posedge gpu_clk or negedge rst) begin
        if (!rst) begin
            r_hc <= '0;
            r_vc <= '0;
        end else if (w_h_last) begin
            r_hc <= '0;
            r_vc <= w_v_last ? '0 : r_vc + CNT_W'(1);
        end else begin
            r_hc <= r_hc + CNT_W'(1);
        end
    end

    // Combinational decode of the current counter position
    always_comb begin
        w_v_act        = (r_vc < CNT_W'(V_VISIBLE));
        w_in_game      = (r_hc >= CNT_W'(GAME_X_OFFSET)) &&
                         (r_hc <= CNT_W'(GAME_X_LAST)) && w_v_act;
        w_cx           = '0;
        w_cy           = '0;
        w_line_start   = (r_hc == '0) && w_v_act;
        w_vblank_start = (r_hc == '0) && (r_vc == CNT_W'(V_VISIBLE));
        w_strb         = STRB_IDLE;
        if (w_in_game) begin
            // Each game column spans two pixel clocks
            w_cx = 8'((r_hc - CNT_W'(GAME_X_OFFSET)) >> 1);
        end
        if (w_v_act) begin
            w_cy = 8'(r_vc >> 1);
        end
        w_strb[B_HS]  = !((r_hc >= CNT_W'(H_SYNC_FIRST)) && (r_hc <= CNT_W'(H_SYNC_LAST)));
        w_strb[B_VS]  = !((r_vc >= CNT_W'(V_SYNC_FIRST)) && (r_vc <= CNT_W'(V_SYNC_LAST)));
        w_strb[B_VIS] = (r_hc < CNT_W'(H_VISIBLE)) && w_v_act;
    end

    // Coordinate and pulse registers, one cycle behind the counters
    always_ff @(posedge gpu_clk or negedge rst) begin
        if (!rst) begin
            r_cx           <= '0;
            r_cy           <= '0;
            r_in_game      <= 1'b0;
            r_line_start   <= 1'b0;
            r_vblank_start <= 1'b0;
        end else begin
            r_cx           <= w_cx;
            r_cy           <= w_cy;
            r_in_game      <= w_in_game;
            r_line_start   <= w_line_start;
            r_vblank_start <= w_vblank_start;
        end
    end

    // Stage 0 is the decode register; further stages align sync with the colour pipeline
    generate
        if (SYNC_DELAY == 0) begin : g_no_delay
            always_ff @(posedge gpu_clk or negedge rst) begin
                if (!rst) begin
                    r_pipe <= STRB_IDLE;
                end else begin
                    r_pipe <= w_strb;
                end
            end
        end else begin : g_delay
            always_ff @(posedge gpu_clk or negedge rst) begin
                if (!rst) begin
                    r_pipe <= {(SYNC_DELAY + 1){STRB_IDLE}};
                end else begin
                    r_pipe <= {r_pipe[STRB_W*SYNC_DELAY-1:0], w_strb};
                end
            end
        end
    endgenerate

    assign o_vid.current_x    = r_cx;
    assign o_vid.current_y    = r_cy;
    assign o_vid.in_game      = r_in_game;
    assign o_vid.line_start   = r_line_start;
    assign o_vid.vblank_start = r_vblank_start;
    assign o_vid.hsync        = r_pipe[STRB_W*SYNC_DELAY + B_HS];
    assign o_vid.vsync        = r_pipe[STRB_W*SYNC_DELAY + B_VS];
    assign o_vid.visible      = r_pipe[STRB_W*SYNC_DELAY + B_VIS];

endmodule

// File: tb/tb_video_timing_m.sv
// Scoreboard bench for video_timing_m: two instances (SYNC_DELAY 1 and 3) on a
// shortened vertical raster, checked every cycle against a position-based model.
module tb_video_timing_m;

    localparam int HV = 640;
    localparam int HF = 4;
    localparam int HS = 8;
    localparam int HB = 4;
    localparam int VV = 20;
    localparam int VF = 2;
    localparam int VS = 2;
    localparam int VB = 2;
    localparam int GX = 64;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME = HT * VT;

    typedef struct packed {
        logic [7:0] cx;
        logic [7:0] cy;
        logic       ig;
        logic       hs;
        logic       vs;
        logic       vis;
        logic       ls;
        logic       vbs;
    } exp_t;

    logic clk;
    logic rst;

    video_timing_m_if vid1 ();
    video_timing_m_if vid3 ();

    video_timing_m #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .GAME_X_OFFSET(GX), .SYNC_DELAY(1)
    ) u_dut1 (
        .gpu_clk (clk),
        .rst     (rst),
        .o_vid   (vid1)
    );

    video_timing_m #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .GAME_X_OFFSET(GX), .SYNC_DELAY(3)
    ) u_dut3 (
        .gpu_clk (clk),
        .rst     (rst),
        .o_vid   (vid3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   edges    = 0;
    exp_t q1[$];
    exp_t q3[$];

    // Expected outputs after the e-th rising edge since reset release (e=0: in reset)
    function automatic exp_t model(input int e, input int sd);
        exp_t r;
        int   p;
        int   h;
        int   v;
        r    = '0;
        r.hs = 1'b1;
        r.vs = 1'b1;
        if (e >= 1) begin
            p    = e - 1;
            h    = p % HT;
            v    = (p / HT) % VT;
            r.ig = (h >= GX) && (h < GX + 512) && (v < VV);
            r.cx = r.ig ? 8'((h - GX) / 2) : 8'd0;
            r.cy = (v < VV) ? 8'(v / 2) : 8'd0;
            r.ls = (h == 0) && (v < VV);
            r.vbs = (h == 0) && (v == VV);
        end
        if (e >= 1 + sd) begin
            p     = e - 1 - sd;
            h     = p % HT;
            v     = (p / HT) % VT;
            r.hs  = !((h >= HV + HF) && (h < HV + HF + HS));
            r.vs  = !((v >= VV + VF) && (v < VV + VF + VS));
            r.vis = (h < HV) && (v < VV);
        end
        return r;
    endfunction

    function automatic exp_t got1();
        return {vid1.current_x, vid1.current_y, vid1.in_game, vid1.hsync,
                vid1.vsync, vid1.visible, vid1.line_start, vid1.vblank_start};
    endfunction

    function automatic exp_t got3();
        return {vid3.current_x, vid3.current_y, vid3.in_game, vid3.hsync,
                vid3.vsync, vid3.visible, vid3.line_start, vid3.vblank_start};
    endfunction

    task automatic check(input string name, input exp_t got, input exp_t exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s t=%0t edge=%0d got cx=%0d cy=%0d ig=%b hs=%b vs=%b vis=%b ls=%b vbs=%b want cx=%0d cy=%0d ig=%b hs=%b vs=%b vis=%b ls=%b vbs=%b",
                     name, $time, edges, got.cx, got.cy, got.ig, got.hs, got.vs, got.vis, got.ls, got.vbs,
                     exp.cx, exp.cy, exp.ig, exp.hs, exp.vs, exp.vis, exp.ls, exp.vbs);
        end
    endtask

    // Reference side: every rising edge queues what each DUT must show this cycle
    always @(posedge clk) begin
        if (!rst) edges = 0;
        else      edges++;
        q1.push_back(model(edges, 1));
        q3.push_back(model(edges, 3));
    end

    // Monitor: compare the presented outputs mid-cycle
    always @(negedge clk) begin
        if (q1.size() > 0) check("cycle_sd1", got1(), q1.pop_front());
        if (q3.size() > 0) check("cycle_sd3", got3(), q3.pop_front());
    end

    initial begin
        rst = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (FRAME + 2 * HT) @(negedge clk);

        // Randomly placed mid-frame resets, asserted between clock edges
        for (int k = 0; k < 3; k++) begin
            repeat ($urandom_range(200, FRAME / 2)) @(negedge clk);
            #2 rst = 1'b0;
            #1;
            check("async_rst_sd1", got1(), model(0, 1));
            check("async_rst_sd3", got3(), model(0, 3));
            repeat ($urandom_range(1, 4)) @(negedge clk);
            rst = 1'b1;
        end

        // Run past the next vblank_start and one full wrap after the last release
        repeat (FRAME + 10) @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
